// File: rtl/serdes_pkg.sv
// Shared types and default constants for the serdes receive framer.
package serdes_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } framer_state_t;

  localparam logic [7:0] SYNC_WORD_DEF  = 8'hA5;
  localparam int         FRAME_LEN_DEF  = 4;
  localparam int         LOCK_COUNT_DEF = 3;
  localparam int         LOSS_COUNT_DEF = 2;

  // byte_cnt must hold 0..FRAME_LEN, where FRAME_LEN marks the sync slot
  localparam int BYTE_CNT_W = $clog2(FRAME_LEN_DEF + 1);
  localparam int HIT_CNT_W  = 4;

endpackage

// File: rtl/serdes_rx_shift.sv
// Serial-in shift register with bit-strobe qualifier and byte-phase counter.
module serdes_rx_shift (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_ser_in,
  input  logic       i_ser_en,
  input  logic       i_align,
  output logic [7:0] o_shreg_next,
  output logic       o_byte_done
);

  logic [7:0] r_shreg;
  logic [2:0] r_bit_cnt;

  assign o_shreg_next = i_ser_en ? {r_shreg[6:0], i_ser_in} : r_shreg;
  assign o_byte_done  = i_ser_en && (r_bit_cnt == 3'd7);

  // i_align restarts byte phase so the following bit is bit 0 of a new byte
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shreg   <= 8'h00;
      r_bit_cnt <= 3'd0;
    end else if (i_ser_en) begin
      r_shreg   <= o_shreg_next;
      r_bit_cnt <= i_align ? 3'd0 : r_bit_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/serdes_rx_framer.sv
// Receive framer: hunts for the sync byte, confirms alignment, then emits aligned bytes.
//   state   | meaning
//   HUNT    | bit-by-bit search for SYNC_WORD, no byte alignment
//   CONFIRM | aligned, counting consecutive good sync slots toward lock
//   LOCKED  | delivering data bytes, flywheeling through isolated sync misses
module serdes_rx_framer
  import serdes_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD  = SYNC_WORD_DEF,
  parameter int         FRAME_LEN  = FRAME_LEN_DEF,
  parameter int         LOCK_COUNT = LOCK_COUNT_DEF,
  parameter int         LOSS_COUNT = LOSS_COUNT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_ser_in,
  input  logic       i_ser_en,
  output logic [7:0] o_data_out,
  output logic       o_data_valid,
  output logic       o_frame_start,
  output logic       o_locked,
  output logic       o_sync_err
);

  localparam int                    BCW       = $clog2(FRAME_LEN + 1);
  localparam logic [BCW-1:0]        SYNC_SLOT = BCW'(FRAME_LEN);
  localparam logic [HIT_CNT_W-1:0]  LOCK_C    = HIT_CNT_W'(LOCK_COUNT);
  localparam logic [HIT_CNT_W-1:0]  LOSS_C    = HIT_CNT_W'(LOSS_COUNT);

  logic [7:0]           w_shreg_next;
  logic                 w_byte_done;
  logic                 w_align;
  logic                 w_sync_hit;
  logic                 w_sync_slot;

  framer_state_t        r_state, w_state_nxt;
  logic [BCW-1:0]       r_byte_cnt, w_byte_cnt_nxt;
  logic [HIT_CNT_W-1:0] r_hits, w_hits_nxt;
  logic [HIT_CNT_W-1:0] r_miss, w_miss_nxt;
  logic [7:0]           r_data, w_data_nxt;
  logic                 r_valid, w_valid_nxt;
  logic                 r_fs, w_fs_nxt;
  logic                 r_err, w_err_nxt;

  serdes_rx_shift u_shift (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_ser_in     (i_ser_in),
    .i_ser_en     (i_ser_en),
    .i_align      (w_align),
    .o_shreg_next (w_shreg_next),
    .o_byte_done  (w_byte_done)
  );

  assign w_sync_hit  = (w_shreg_next == SYNC_WORD);
  assign w_sync_slot = (r_byte_cnt == SYNC_SLOT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= HUNT;
      r_byte_cnt <= '0;
      r_hits     <= '0;
      r_miss     <= '0;
      r_data     <= 8'h00;
      r_valid    <= 1'b0;
      r_fs       <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_hits     <= w_hits_nxt;
      r_miss     <= w_miss_nxt;
      r_data     <= w_data_nxt;
      r_valid    <= w_valid_nxt;
      r_fs       <= w_fs_nxt;
      r_err      <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_byte_cnt_nxt = r_byte_cnt;
    w_hits_nxt     = r_hits;
    w_miss_nxt     = r_miss;
    w_data_nxt     = r_data;
    w_valid_nxt    = 1'b0;
    w_fs_nxt       = 1'b0;
    w_err_nxt      = 1'b0;
    w_align        = 1'b0;

    case (r_state)
      HUNT: begin
        if (i_ser_en && w_sync_hit) begin
          w_align        = 1'b1;
          w_byte_cnt_nxt = '0;
          w_hits_nxt     = HIT_CNT_W'(1);
          w_miss_nxt     = '0;
          w_state_nxt    = (LOCK_C == HIT_CNT_W'(1)) ? LOCKED : CONFIRM;
        end
      end

      CONFIRM: begin
        if (w_byte_done) begin
          if (!w_sync_slot) begin
            w_byte_cnt_nxt = r_byte_cnt + 1'b1;
          end else begin
            w_byte_cnt_nxt = '0;
            if (w_sync_hit) begin
              w_hits_nxt = r_hits + 1'b1;
              if ((r_hits + 1'b1) == LOCK_C) begin
                w_state_nxt = LOCKED;
                w_miss_nxt  = '0;
              end
            end else begin
              w_err_nxt   = 1'b1;
              w_state_nxt = HUNT;
            end
          end
        end
      end

      LOCKED: begin
        if (w_byte_done) begin
          if (!w_sync_slot) begin
            w_data_nxt     = w_shreg_next;
            w_valid_nxt    = 1'b1;
            w_fs_nxt       = (r_byte_cnt == '0);
            w_byte_cnt_nxt = r_byte_cnt + 1'b1;
          end else begin
            w_byte_cnt_nxt = '0;
            if (w_sync_hit) begin
              w_miss_nxt = '0;
            end else begin
              // slot timing is kept on a single miss; only a run of misses drops lock
              w_err_nxt  = 1'b1;
              w_miss_nxt = r_miss + 1'b1;
              if ((r_miss + 1'b1) == LOSS_C) begin
                w_state_nxt = HUNT;
              end
            end
          end
        end
      end

      default: w_state_nxt = HUNT;
    endcase
  end

  assign o_data_out    = r_data;
  assign o_data_valid  = r_valid;
  assign o_frame_start = r_fs;
  assign o_locked      = (r_state == LOCKED);
  assign o_sync_err    = r_err;

endmodule
